// File: rtl/toi2s_pkg.sv
// Shared types and constants for the toi2s amplifier control path.
package toi2s_pkg;

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StPwrup    = 3'd1,
        StIssue    = 3'd2,
        StWait     = 3'd3,
        StLockWait = 3'd4,
        StRun      = 3'd5,
        StFault    = 3'd6
    } seq_state_e;

    localparam logic [15:0] CMD_TERM         = 16'h0000;
    localparam logic [6:0]  AMP_ADDR_DEFAULT = 7'h4C;

endpackage

// File: rtl/toi2s_seq_timer.sv
// Loadable counter with terminal flag: counts down to 0, or (CountUp) up to Limit.
// Holds at the terminal value until reloaded.
module toi2s_seq_timer #(
    parameter int unsigned Width   = 12,
    parameter bit          CountUp = 1'b0,
    parameter int unsigned Limit   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    localparam logic [Width-1:0] LimitW = Width'(Limit);

    logic [Width-1:0] count_q, count_d;

    // "zero" means no distance left to the terminal count in either mode.
    assign zero = CountUp ? (count_q == LimitW) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && !zero) begin
            count_d = CountUp ? count_q + Width'(1) : count_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/amp_ctrl_seq.sv
// Amplifier power-up / I2C init / lock-gated unmute sequencer.
// Build option AMP_SEQ_RETRY_EN: retry each NACKed write up to twice before faulting.
module amp_ctrl_seq
    import toi2s_pkg::*;
#(
    parameter int unsigned N_CMDS       = 8,
    parameter logic [6:0]  AMP_ADDR     = AMP_ADDR_DEFAULT,
    parameter int unsigned PWRUP_CYCLES = 4096,
    parameter int unsigned LOCK_HOLD    = 1024,
    localparam int unsigned IdxW        = (N_CMDS > 1) ? $clog2(N_CMDS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            mute_req,
    input  logic            lock,
    output logic [IdxW-1:0] cmd_idx,
    input  logic [15:0]     cmd_data,
    output logic            m_req,
    output logic [6:0]      m_dev,
    output logic [7:0]      m_reg,
    output logic [7:0]      m_data,
    input  logic            m_done,
    input  logic            m_nack,
    output logic            amp_nenable,
    output logic            amp_nmute,
    output logic            busy,
    output logic            err,
    output logic [2:0]      state
);

    localparam int unsigned PwrW  = (PWRUP_CYCLES > 2) ? $clog2(PWRUP_CYCLES) : 1;
    localparam int unsigned LockW = $clog2(LOCK_HOLD + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CMDS - 1);

    seq_state_e      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            end_q, end_d;    // last table slot already written
    logic [7:0]      m_reg_q, m_reg_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            m_req_q;
    logic            nenable_q, nmute_q, busy_q;
    logic            err_q, err_d;
    logic            pwr_load, pwr_zero;
    logic            lock_clr, lock_reached;

`ifdef AMP_SEQ_RETRY_EN
    localparam logic [1:0] MaxRetry = 2'd2;
    logic [1:0] retry_q, retry_d;
`endif

    toi2s_seq_timer #(
        .Width   (PwrW),
        .CountUp (1'b0),
        .Limit   (0)
    ) u_pwr_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (pwr_load),
        .load_val (PwrW'(PWRUP_CYCLES - 1)),
        .en       (state_q == StPwrup),
        .zero     (pwr_zero)
    );

    // Counts consecutive lock cycles while waiting; any gap or other state clears it.
    assign lock_clr = !((state_q == StLockWait) && lock);

    toi2s_seq_timer #(
        .Width   (LockW),
        .CountUp (1'b1),
        .Limit   (LOCK_HOLD)
    ) u_lock_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (lock_clr),
        .load_val ('0),
        .en       (1'b1),
        .zero     (lock_reached)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        end_d    = end_q;
        m_reg_d  = m_reg_q;
        m_data_d = m_data_q;
        pwr_load = 1'b0;
`ifdef AMP_SEQ_RETRY_EN
        retry_d  = retry_q;
`endif
        unique case (state_q)
            StOff: begin
                if (enable) begin
                    state_d  = StPwrup;
                    pwr_load = 1'b1;
                    idx_d    = '0;
                    end_d    = 1'b0;
`ifdef AMP_SEQ_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            StPwrup: begin
                if (!enable)       state_d = StOff;
                else if (pwr_zero) state_d = StIssue;
            end
            StIssue: begin
                if (!enable) begin
                    state_d = StOff;
                end else if (end_q || (cmd_data == CMD_TERM)) begin
                    state_d = StLockWait;
                end else begin
                    m_reg_d  = cmd_data[15:8];
                    m_data_d = cmd_data[7:0];
                    state_d  = StWait;
                end
            end
            StWait: begin
                // An open transaction always runs to m_done, even when disabled.
                if (m_done) begin
                    if (!enable) begin
                        state_d = StOff;
                    end else if (!m_nack) begin
                        state_d = StIssue;
`ifdef AMP_SEQ_RETRY_EN
                        retry_d = '0;
`endif
                        if (idx_q == LastIdx) end_d = 1'b1;
                        else                  idx_d = idx_q + IdxW'(1);
                    end else begin
`ifdef AMP_SEQ_RETRY_EN
                        if (retry_q == MaxRetry) begin
                            state_d = StFault;
                        end else begin
                            retry_d = retry_q + 2'd1;
                            state_d = StIssue;
                        end
`else
                        state_d = StFault;
`endif
                    end
                end
            end
            StLockWait: begin
                if (!enable)                                 state_d = StOff;
                else if (lock_reached && lock && !mute_req) state_d = StRun;
            end
            StRun: begin
                if (!enable)               state_d = StOff;
                else if (!lock || mute_req) state_d = StLockWait;
            end
            StFault: begin
                if (!enable) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

    // err is sticky through OFF so software can see why the amp shut down.
    always_comb begin
        err_d = err_q;
        if (state_d == StFault)                                 err_d = 1'b1;
        else if ((state_q == StOff) && (state_d == StPwrup))    err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StOff;
            idx_q     <= '0;
            end_q     <= 1'b0;
            m_reg_q   <= '0;
            m_data_q  <= '0;
            m_req_q   <= 1'b0;
            nenable_q <= 1'b1;
            nmute_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef AMP_SEQ_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            end_q     <= end_d;
            m_reg_q   <= m_reg_d;
            m_data_q  <= m_data_d;
            // Request trails WAIT entry by a cycle, giving a two-cycle gap between writes.
            m_req_q   <= (state_q == StWait) && !m_done;
            nenable_q <= (state_d == StOff) || (state_d == StFault);
            nmute_q   <= (state_d == StRun);
            busy_q    <= !(state_d inside {StOff, StRun, StFault});
            err_q     <= err_d;
`ifdef AMP_SEQ_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign cmd_idx     = idx_q;
    assign m_req       = m_req_q;
    assign m_dev       = AMP_ADDR;
    assign m_reg       = m_reg_q;
    assign m_data      = m_data_q;
    assign amp_nenable = nenable_q;
    assign amp_nmute   = nmute_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign state       = state_q;

endmodule
